uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART byte transmitter (`transmit`) among up to N message sources: fixed messages, echo, status dumps. Grants the transmitter one whole message at a time under round-robin priority and feeds it byte by byte through the `word` / `connection_status` / `transmit_ready` handshake. Enforces an idle gap between messages, and aborts a message whose source stalls or overruns the length limit.

## Interface
- `N`, 4: number of requesters (2..8).
- `GAP_CYCLES`, 16: idle cycles between messages, minimum 1.
- `STALL_MAX`, 1023: cycles a granted source may leave `req_valid` low before abort.
- `MAX_LEN`, 255: maximum bytes per message.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in N: requester i has a byte on its data slice.
- `req_data` in 8N: byte for requester i, at bits [8i+7:8i].
- `req_last` in N: the byte on slice i is the last byte of its message.
- `req_ready` out N: one-cycle pulse; byte i consumed this cycle.
- `word` out 8: byte presented to the transmitter.
- `connection_status` out 1: high means `word` is valid and the transmitter may send it.
- `transmit_ready` in 1: one-cycle pulse; the transmitter has captured `word`.
- `grant` out N: one-hot owner of the current message; zero when no message is owned.
- `busy` out 1: high in any state other than IDLE.
- `err_stall` out 1: one-cycle pulse when a message is aborted for stall.
- `err_len` out 1: one-cycle pulse when a message is aborted for length.

## Operation
- States: IDLE, LOAD, SEND, GAP.
- **IDLE**
  - Search priority starts at pointer `ptr`.
  - The first i with `req_valid[i]` wins: `grant` is set one-hot, byte count is cleared, go to LOAD.
  - With no valid requester, stay in IDLE.
- **LOAD**
  - If `req_valid[g]` is high: latch `req_data[g]` into `word` and `req_last[g]` into `last_q`, pulse `req_ready[g]`, increment the count, clear the stall counter, go to SEND.
  - If `req_valid[g]` is low: increment the stall counter. When it reaches `STALL_MAX`, pulse `err_stall` and go to GAP.
- **SEND**
  - `connection_status` is 1 and `word` is held stable.
  - On `transmit_ready` with `last_q` set, go to GAP.
  - On `transmit_ready` with the count equal to `MAX_LEN`, pulse `err_len` and go to GAP.
  - On any other `transmit_ready`, go to LOAD.
  - `last_q` takes priority over `MAX_LEN`: a last byte at exactly `MAX_LEN` is not an error.
- **GAP**
  - On entry: `grant` is cleared and `ptr` becomes (g+1) mod N.
  - Count `GAP_CYCLES` cycles, then go to IDLE.
- `connection_status` is 0 in IDLE, LOAD and GAP.
- `transmit_ready` outside SEND is ignored.
- Requesters that change `req_valid` while not granted have no effect.
- Widths:
  - Byte counter: clog2(`MAX_LEN`+1) bits.
  - Stall counter: clog2(`STALL_MAX`+1) bits.
  - Gap counter: clog2(`GAP_CYCLES`+1) bits.
  - No counter wraps; each is compared for equality and then reset.

## Timing
- Reset values:
  - `word` = 0, `connection_status` = 0, `grant` = 0, `req_ready` = 0.
  - `busy` = 0, both error flags = 0.
  - `ptr` = 0, state = IDLE.
- Reset has priority over every transition. Reset mid-message drops `connection_status` in the same cycle and discards the partial message.
- Request to first `connection_status`: 2 cycles (IDLE, then LOAD) with valid data present.
- Byte turnaround after `transmit_ready`: `word` is updated and `connection_status` reasserted 2 cycles later (LOAD, then SEND). `connection_status` is low for exactly one cycle between bytes.
- All outputs are registered.
- `req_ready` and the error pulses last exactly one cycle.
- `transmit_ready` arriving on the same edge as a state exit is consumed once only.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE/LOAD/SEND/GAP);
  - the byte type (8 bits);
  - the default `GAP_CYCLES`, `STALL_MAX` and `MAX_LEN` constants.
- One sub-module, `rr_pick`: combinational rotate-and-priority-encode of `req_valid` by `ptr`, producing a one-hot winner and a found flag.
- The `transmit` instance lives in the parent, not in this block.

## Test plan
- **Single source:** requester 0 sends "Hi\n" (3 bytes, `last` on '\n'), with `transmit_ready` modelled 10 cycles after each `connection_status` rise. Required: `word` = 0x48, 0x69, 0x0A in order; 3 `req_ready` pulses; `grant` = 0001 throughout; GAP lasts 16 cycles.
- **Round-robin:** requesters 0 and 2 both hold 2-byte messages at reset release. Required: 0 is served first, then 2, then 0 again. No interleaving of bytes within a message.
- **Stall:** requester 1 supplies 1 byte, then drops `req_valid`. Required: `err_stall` pulses 1023 cycles after entering LOAD, `grant` clears, and the next requester is served after the gap.
- **Length:** `MAX_LEN` = 4 and a source that never asserts `last`. Required: exactly 4 bytes sent, `err_len` pulses on the 4th `transmit_ready`, and no 5th `req_ready`.
- **Reset mid-SEND:** assert `rst` = 0 for one cycle during byte 2. Required: next cycle `connection_status` = 0, `grant` = 0, `ptr` = 0.
- **Stray `transmit_ready`:** pulse `transmit_ready` in IDLE and GAP. Required: no state change and no `req_ready`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default limits for the UART transmit arbiter.
package uart_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    // One UART byte.
    typedef logic [7:0] byte_t;

    // Default limits.
    localparam int DEF_GAP_CYCLES = 16;
    localparam int DEF_STALL_MAX  = 1023;
    localparam int DEF_MAX_LEN    = 255;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner select: first valid requester at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          found
);

    // Walk the requesters starting at ptr; the first valid one wins.
    always_comb begin
        logic [PW-1:0] j;
        pick  = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!found && valid[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among N message sources, one whole
// message at a time, round-robin, with an idle gap and stall/length aborts.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N          = 4,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int STALL_MAX  = DEF_STALL_MAX,
    parameter int MAX_LEN    = DEF_MAX_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output byte_t          word,
    output logic           connection_status,
    input  logic           transmit_ready,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           err_stall,
    output logic           err_len
);

    localparam int PW = $clog2(N);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t        state, nstate;
    logic [PW-1:0] ptr, ptr_next;
    logic [LW-1:0] byte_cnt;
    logic [SW-1:0] stall_cnt;
    logic [GW-1:0] gap_cnt;
    logic          last_q;

    logic [N-1:0]  pick;
    logic          found;
    logic          sel_valid, sel_last;
    byte_t         sel_data;
    logic          abort_stall, abort_len;
    logic          cs_d, busy_d;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .pick  (pick),
        .found (found)
    );

    // Route the owner's request lines and compute the pointer past the owner.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        ptr_next  = ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
                ptr_next  = PW'((i + 1) % N);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    // Next-state logic; abort flags mark the two error exits.
    always_comb begin
        nstate      = state;
        abort_stall = 1'b0;
        abort_len   = 1'b0;
        case (state)
            IDLE: if (found) nstate = LOAD;
            LOAD: begin
                if (sel_valid) begin
                    nstate = SEND;
                end else if (stall_cnt == SW'(STALL_MAX - 1)) begin
                    nstate      = GAP;
                    abort_stall = 1'b1;
                end
            end
            SEND: begin
                // last byte wins over the length limit
                if (transmit_ready) begin
                    if (last_q) begin
                        nstate = GAP;
                    end else if (byte_cnt == LW'(MAX_LEN)) begin
                        nstate    = GAP;
                        abort_len = 1'b1;
                    end else begin
                        nstate = LOAD;
                    end
                end
            end
            GAP:  if (gap_cnt == GW'(GAP_CYCLES - 1)) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Output decode from the next state, registered below so outputs are flops.
    always_comb begin
        cs_d   = (nstate == SEND);
        busy_d = (nstate != IDLE);
    end

    // Datapath: grant, byte latch, counters, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word              <= '0;
            connection_status <= 1'b0;
            grant             <= '0;
            req_ready         <= '0;
            busy              <= 1'b0;
            err_stall         <= 1'b0;
            err_len           <= 1'b0;
            ptr               <= '0;
            byte_cnt          <= '0;
            stall_cnt         <= '0;
            gap_cnt           <= '0;
            last_q            <= 1'b0;
        end else begin
            req_ready         <= '0;
            err_stall         <= abort_stall;
            err_len           <= abort_len;
            connection_status <= cs_d;
            busy              <= busy_d;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= pick;
                        byte_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (sel_valid) begin
                        word      <= sel_data;
                        last_q    <= sel_last;
                        req_ready <= grant;
                        byte_cnt  <= byte_cnt + LW'(1);
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= abort_stall ? '0 : stall_cnt + SW'(1);
                    end
                end
                GAP: begin
                    gap_cnt <= (nstate == IDLE) ? '0 : gap_cnt + GW'(1);
                end
                default: ;
            endcase
            // Entering the gap releases the owner and advances the pointer.
            if (nstate == GAP && state != GAP) begin
                grant   <= '0;
                ptr     <= ptr_next;
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based sources, a delayed
// transmitter model, and a round-robin message-order reference model.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int ML = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]     word;
    logic           connection_status, transmit_ready, busy, err_stall, err_len;
    logic           tx_pulse, stray;

    assign transmit_ready = tx_pulse | stray;

    uart_tx_arbiter #(.N(N), .GAP_CYCLES(16), .STALL_MAX(1023), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .word(word),
        .connection_status(connection_status), .transmit_ready(transmit_ready),
        .grant(grant), .busy(busy), .err_stall(err_stall), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;

    // source queues: {last, byte}
    logic [8:0] mem [N][128];
    int head [N], tail [N], rdy_cnt [N];
    int n_stall, n_len, stall_cyc, len_cyc;
    logic [N-1:0] gnt_at_err;

    // transmitter model and logs
    bit tx_en = 0, tx_rand = 0;
    int tx_delay = 9, cs_cnt = 0;
    logic cs_prev = 1'b0;
    logic [7:0]   log_byte [256];
    logic [N-1:0] log_gnt [256];
    int log_cyc [256], rise_cyc [256];
    int log_n = 0, rise_n = 0;

    // reference-model message tables
    int mcnt [N];
    int mlen [N][4];
    logic [7:0] mb [N][4][4];
    logic [7:0] exp_b [64];
    int exp_g [64];
    int exp_n;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sources: consume on req_ready, present queue head.
    initial begin
        req_valid = '0; req_last = '0; req_data = '0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; rdy_cnt[i] = 0; end
        n_stall = 0; n_len = 0; stall_cyc = 0; len_cyc = 0; gnt_at_err = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    rdy_cnt[i]++;
                    if (head[i] != tail[i]) head[i]++;
                end
            end
            if (err_stall) begin n_stall++; stall_cyc = cyc; gnt_at_err = grant; end
            if (err_len) begin n_len++; len_cyc = cyc; end
            for (int i = 0; i < N; i++) begin
                req_valid[i]       = (head[i] != tail[i]);
                req_data[8*i +: 8] = (head[i] != tail[i]) ? mem[i][head[i]][7:0] : 8'h00;
                req_last[i]        = (head[i] != tail[i]) ? mem[i][head[i]][8] : 1'b0;
            end
        end
    end

    // Transmitter: captures word tx_delay cycles after connection_status rises.
    initial begin
        tx_pulse = 1'b0;
        forever begin
            @(negedge clk);
            tx_pulse = 1'b0;
            if (connection_status && !cs_prev && rise_n < 256) begin
                rise_cyc[rise_n] = cyc; rise_n++;
            end
            cs_prev = connection_status;
            if (connection_status && tx_en) begin
                if (cs_cnt >= tx_delay) begin
                    tx_pulse = 1'b1;
                    if (log_n < 256) begin
                        log_byte[log_n] = word; log_gnt[log_n] = grant; log_cyc[log_n] = cyc;
                        log_n++;
                    end
                    cs_cnt = 0;
                    if (tx_rand) tx_delay = $urandom_range(0, 4);
                end else begin
                    cs_cnt++;
                end
            end else begin
                cs_cnt = 0;
            end
        end
    end

    task automatic push(input int i, input logic [7:0] b, input logic l);
        mem[i][tail[i]] = {l, b};
        tail[i]++;
    endtask

    task automatic clear_logs();
        log_n = 0; rise_n = 0; n_stall = 0; n_len = 0;
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();
    endtask

    // Wait for nbytes captured and the arbiter back in IDLE.
    task automatic wait_done(input int nbytes, input int bound, output bit ok, output int fall);
        ok = 0; fall = 0;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk); #1;
            if (log_n >= nbytes && !busy) begin ok = 1; fall = cyc; break; end
        end
    endtask

    // Round-robin reference: each grant serves one whole message.
    function automatic void build_expected();
        int rem [N];
        int nxt [N];
        int p, total, w;
        p = 0; exp_n = 0; total = 0;
        for (int i = 0; i < N; i++) begin rem[i] = mcnt[i]; nxt[i] = 0; total += mcnt[i]; end
        while (total > 0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && rem[(p + k) % N] > 0) w = (p + k) % N;
            for (int b = 0; b < mlen[w][nxt[w]]; b++) begin
                exp_b[exp_n] = mb[w][nxt[w]][b]; exp_g[exp_n] = w; exp_n++;
            end
            nxt[w]++; rem[w]--; total--;
            p = (w + 1) % N;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b0; stray = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if (word !== 8'h00) begin n_fail++; $display("FAIL reset_word: got %h want 00", word); end
        n_chk++; if (connection_status !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", connection_status); end
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_chk++; if (busy !== 1'b0 || err_stall !== 1'b0 || err_len !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got busy=%b es=%b el=%b want 0 0 0", busy, err_stall, err_len);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();
    endtask

    task automatic test_single();
        bit ok; int fall, c0;
        logic [7:0] hi [3];
        hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;
        reset_dut();
        tx_en = 1; tx_rand = 0; tx_delay = 9;
        push(0, 8'h48, 1'b0); push(0, 8'h69, 1'b0); push(0, 8'h0A, 1'b1);
        c0 = cyc;
        wait_done(3, 500, ok, fall);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d bytes want 3", log_n); end
        for (int b = 0; b < 3; b++) begin
            n_chk++; if (log_byte[b] !== hi[b]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", b, log_byte[b], hi[b]); end
            n_chk++; if (log_gnt[b] !== 4'b0001) begin n_fail++; $display("FAIL single_grant%0d: got %b want 0001", b, log_gnt[b]); end
        end
        n_chk++; if (rdy_cnt[0] != 3) begin n_fail++; $display("FAIL single_ready_count: got %0d want 3", rdy_cnt[0]); end
        n_chk++; if (rise_cyc[0] - c0 != 2) begin n_fail++; $display("FAIL single_first_latency: got %0d want 2", rise_cyc[0] - c0); end
        for (int b = 1; b < 3; b++) begin
            n_chk++; if (rise_cyc[b] - log_cyc[b-1] != 2) begin
                n_fail++; $display("FAIL single_turnaround%0d: got %0d want 2", b, rise_cyc[b] - log_cyc[b-1]);
            end
        end
        // GAP occupies 16 cycles after the capturing edge, busy drops on the next
        n_chk++; if (fall - log_cyc[2] != 17) begin n_fail++; $display("FAIL single_gap: got %0d want 17", fall - log_cyc[2]); end
    endtask

    task automatic test_round_robin();
        bit ok; int fall;
        logic [7:0] eb [6];
        logic [N-1:0] eg [6];
        reset_dut();
        tx_en = 1; tx_rand = 1;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        push(2, 8'hB0, 1'b0); push(2, 8'hB1, 1'b1);
        eb[0] = 8'hA0; eb[1] = 8'hA1; eb[2] = 8'hB0; eb[3] = 8'hB1; eb[4] = 8'hA2; eb[5] = 8'hA3;
        eg[0] = 4'b0001; eg[1] = 4'b0001; eg[2] = 4'b0100; eg[3] = 4'b0100; eg[4] = 4'b0001; eg[5] = 4'b0001;
        wait_done(6, 1000, ok, fall);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d bytes want 6", log_n); end
        for (int b = 0; b < 6; b++) begin
            n_chk++; if (log_byte[b] !== eb[b] || log_gnt[b] !== eg[b]) begin
                n_fail++; $display("FAIL rr_entry%0d: got %h/%b want %h/%b", b, log_byte[b], log_gnt[b], eb[b], eg[b]);
            end
        end
    endtask

    task automatic test_random();
        bit ok; int fall, tot, rsum;
        for (int it = 0; it < 3; it++) begin
            reset_dut();
            tx_en = 1; tx_rand = 1;
            tot = 0;
            for (int i = 0; i < N; i++) begin
                mcnt[i] = $urandom_range(0, 3);
                for (int m = 0; m < mcnt[i]; m++) begin
                    mlen[i][m] = $urandom_range(1, ML);
                    for (int b = 0; b < mlen[i][m]; b++) begin
                        mb[i][m][b] = 8'($urandom);
                        push(i, mb[i][m][b], b == mlen[i][m] - 1);
                        tot++;
                    end
                end
            end
            if (tot == 0) begin
                mcnt[1] = 1; mlen[1][0] = ML;
                for (int b = 0; b < ML; b++) begin mb[1][0][b] = 8'(b + 1); push(1, mb[1][0][b], b == ML - 1); end
                tot = ML;
            end
            build_expected();
            wait_done(exp_n, 3000, ok, fall);
            n_chk++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d bytes want %0d", it, log_n, exp_n); end
            for (int b = 0; b < exp_n; b++) begin
                n_chk++; if (log_byte[b] !== exp_b[b] || log_gnt[b] !== 4'(1 << exp_g[b])) begin
                    n_fail++; $display("FAIL rand%0d_entry%0d: got %h/%b want %h/%b", it, b,
                                       log_byte[b], log_gnt[b], exp_b[b], 4'(1 << exp_g[b]));
                end
            end
            rsum = 0;
            for (int i = 0; i < N; i++) rsum += rdy_cnt[i];
            n_chk++; if (rsum != tot || n_len != 0 || n_stall != 0) begin
                n_fail++; $display("FAIL rand%0d_counts: got rdy=%0d len=%0d stall=%0d want %0d 0 0", it, rsum, n_len, n_stall, tot);
            end
        end
    endtask

    task automatic test_stall();
        bit ok; int fall;
        reset_dut();
        tx_en = 1; tx_rand = 0; tx_delay = 3;
        push(1, 8'h55, 1'b0);
        push(2, 8'h77, 1'b1);
        wait_done(2, 1500, ok, fall);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got %0d bytes want 2", log_n); end
        n_chk++; if (n_stall != 1) begin n_fail++; $display("FAIL stall_pulses: got %0d want 1", n_stall); end
        n_chk++; if (stall_cyc - log_cyc[0] != 1024) begin
            n_fail++; $display("FAIL stall_delay: got %0d want 1024", stall_cyc - log_cyc[0]);
        end
        n_chk++; if (gnt_at_err !== 4'b0000) begin n_fail++; $display("FAIL stall_grant_clear: got %b want 0000", gnt_at_err); end
        n_chk++; if (log_gnt[0] !== 4'b0010 || log_gnt[1] !== 4'b0100 || log_byte[1] !== 8'h77) begin
            n_fail++; $display("FAIL stall_next: got %b,%b/%h want 0010,0100/77", log_gnt[0], log_gnt[1], log_byte[1]);
        end
    endtask

    task automatic test_length();
        bit ok; int fall;
        reset_dut();
        tx_en = 1; tx_rand = 1;
        for (int b = 0; b < 6; b++) push(3, 8'(8'hC0 + b), 1'b0);
        ok = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk); #1;
            if (n_len != 0) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        head[3] = tail[3];
        n_chk++; if (!ok) begin n_fail++; $display("FAIL len_timeout: got no err_len want 1 pulse"); end
        n_chk++; if (len_cyc - log_cyc[3] != 1) begin n_fail++; $display("FAIL len_pulse_time: got %0d want 1", len_cyc - log_cyc[3]); end
        // exact MAX_LEN message with last on the final byte is legal
        push(0, 8'hD0, 1'b0); push(0, 8'hD1, 1'b0); push(0, 8'hD2, 1'b0); push(0, 8'hD3, 1'b1);
        wait_done(8, 1000, ok, fall);
        n_chk++; if (!ok || log_n != 8) begin n_fail++; $display("FAIL len_bytes: got %0d bytes want 8", log_n); end
        n_chk++; if (rdy_cnt[3] != 4) begin n_fail++; $display("FAIL len_ready_count: got %0d want 4", rdy_cnt[3]); end
        n_chk++; if (n_len != 1) begin n_fail++; $display("FAIL len_pulses: got %0d want 1", n_len); end
        for (int b = 0; b < 4; b++) begin
            n_chk++; if (log_byte[b] !== 8'(8'hC0 + b) || log_byte[b+4] !== 8'(8'hD0 + b)) begin
                n_fail++; $display("FAIL len_byte%0d: got %h,%h want %h,%h", b, log_byte[b], log_byte[b+4], 8'(8'hC0 + b), 8'(8'hD0 + b));
            end
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok; int fall;
        reset_dut();
        tx_en = 1; tx_rand = 0; tx_delay = 9;
        push(2, 8'h10, 1'b1);
        wait_done(1, 500, ok, fall);
        @(posedge clk); #1;
        clear_logs();
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        ok = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk); #1;
            if (rise_n >= 2 && connection_status) begin ok = 1; break; end
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no second byte"); end
        rst = 1'b0;
        head[2] = tail[2];
        @(negedge clk); #1;
        n_chk++; if (connection_status !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got cs=%b grant=%b busy=%b want 0 0000 0", connection_status, grant, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        push(1, 8'h31, 1'b1); push(3, 8'h33, 1'b1);
        wait_done(2, 500, ok, fall);
        n_chk++; if (!ok || log_gnt[0] !== 4'b0010 || log_gnt[1] !== 4'b1000) begin
            n_fail++; $display("FAIL rstmid_ptr: got %b,%b want 0010,1000", log_gnt[0], log_gnt[1]);
        end
    endtask

    task automatic test_stray_ready();
        bit ok; int fall, rsum;
        reset_dut();
        tx_en = 1; tx_rand = 0; tx_delay = 2;
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rsum = rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3];
        n_chk++; if (busy !== 1'b0 || connection_status !== 1'b0 || rsum != 0) begin
            n_fail++; $display("FAIL stray_idle: got busy=%b cs=%b rdy=%0d want 0 0 0", busy, connection_status, rsum);
        end
        push(0, 8'h5A, 1'b1);
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (log_n >= 1) begin ok = 1; break; end
        end
        repeat (4) @(negedge clk);
        stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        #1;
        n_chk++; if (!ok || busy !== 1'b1 || connection_status !== 1'b0) begin
            n_fail++; $display("FAIL stray_gap_state: got busy=%b cs=%b want 1 0", busy, connection_status);
        end
        wait_done(1, 200, ok, fall);
        n_chk++; if (!ok || fall - log_cyc[0] != 17) begin
            n_fail++; $display("FAIL stray_gap_len: got %0d want 17", fall - log_cyc[0]);
        end
        n_chk++; if (rdy_cnt[0] != 1 || log_n != 1) begin
            n_fail++; $display("FAIL stray_ready: got rdy=%0d bytes=%0d want 1 1", rdy_cnt[0], log_n);
        end
    endtask

    initial begin
        rst = 1'b0; stray = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_stall();
        test_length();
        test_reset_mid_send();
        test_stray_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
